// File: rtl/pcss_axis_link_bridge.sv
// pcss_axis_link_bridge
// Host bridge between a 64-bit AXI-stream port and NUM_LINK PCSS chip links.
// Ingress beats are split into parity-protected chip words on the link selected
// by tdest. Egress words are packed into beats per link and merged round-robin.
// A programmable tik pulse is generated for the chip array.
module pcss_axis_link_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHIPDATA_WIDTH = 16,
  parameter int NUM_LINK       = 4,
  parameter int TIK_WIDTH      = 24,
  localparam int LW = (NUM_LINK > 1) ? $clog2(NUM_LINK) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              S_AXIS_send_tdata,
  input  logic                               S_AXIS_send_tvalid,
  input  logic [LW-1:0]                      S_AXIS_send_tdest,
  output logic                               S_AXIS_send_tready,
  output logic [DATA_WIDTH-1:0]              M_AXIS_recv_tdata,
  output logic                               M_AXIS_recv_tvalid,
  output logic [LW-1:0]                      M_AXIS_recv_tid,
  output logic                               M_AXIS_recv_tlast,
  input  logic                               M_AXIS_recv_tready,
  input  logic                               tik_en,
  input  logic [TIK_WIDTH-1:0]               tik_period,
  output logic                               tik,
  output logic [TIK_WIDTH-1:0]               tik_cnt,
  output logic [NUM_LINK*CHIPDATA_WIDTH-1:0] send_data_out,
  output logic [NUM_LINK-1:0]                send_data_valid,
  output logic [NUM_LINK-1:0]                send_data_par,
  input  logic [NUM_LINK-1:0]                send_data_ready,
  input  logic [NUM_LINK-1:0]                send_data_err,
  input  logic [NUM_LINK*CHIPDATA_WIDTH-1:0] recv_data_in,
  input  logic [NUM_LINK-1:0]                recv_data_valid,
  input  logic [NUM_LINK-1:0]                recv_data_par,
  output logic [NUM_LINK-1:0]                recv_data_ready,
  output logic [NUM_LINK-1:0]                recv_data_err,
  output logic                               status_drop
);

  localparam int CW    = CHIPDATA_WIDTH;
  localparam int RATIO = DATA_WIDTH / CHIPDATA_WIDTH;
  localparam int RW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [RW-1:0] LAST_WORD  = RW'(RATIO - 1);
  localparam logic [LW:0]   NUM_LINK_W = (LW + 1)'(NUM_LINK);
  localparam logic [LW-1:0] LAST_LINK  = LW'(NUM_LINK - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} ing_state_t;

  function automatic logic even_par(input logic [CHIPDATA_WIDTH-1:0] w);
    return ^w;
  endfunction

  // Word i of a beat, most-significant word first.
  function automatic logic [CHIPDATA_WIDTH-1:0] beat_word(input logic [DATA_WIDTH-1:0] b,
                                                          input logic [RW-1:0] i);
    return b[(RATIO - 1 - int'(i)) * CHIPDATA_WIDTH +: CHIPDATA_WIDTH];
  endfunction

  function automatic logic [NUM_LINK-1:0] link_sel(input logic [LW-1:0] d);
    logic [NUM_LINK-1:0] s;
    s = '0;
    for (int k = 0; k < NUM_LINK; k++) s[k] = (LW'(k) == d);
    return s;
  endfunction

  // ---------------- Ingress ----------------
  ing_state_t                   state_r, state_s;
  logic [DATA_WIDTH-1:0]        beat_r, beat_s;
  logic [LW-1:0]                dest_r, dest_s;
  logic [RW-1:0]                widx_r, widx_s;
  logic [NUM_LINK-1:0]          tx_valid_r, tx_valid_s;
  logic [NUM_LINK*CW-1:0]       tx_data_r, tx_data_s;
  logic [NUM_LINK-1:0]          tx_par_r, tx_par_s;
  logic                         tready_r, tready_s;
  logic                         drop_r, drop_s;
  logic                         load_s;
  logic [NUM_LINK-1:0]          load_sel_s;
  logic [CW-1:0]                word_s;
  logic [NUM_LINK-1:0]          sel_r_s;
  logic                         hs_s, nak_s;

  // Ingress next-state: accept, serialize, retry on NAK, drop misrouted beats.
  always_comb begin
    state_s    = state_r;
    beat_s     = beat_r;
    dest_s     = dest_r;
    widx_s     = widx_r;
    tx_valid_s = tx_valid_r;
    tx_data_s  = tx_data_r;
    tx_par_s   = tx_par_r;
    drop_s     = drop_r;
    load_s     = 1'b0;
    load_sel_s = '0;
    word_s     = '0;
    sel_r_s    = link_sel(dest_r);
    hs_s       = |(tx_valid_r & send_data_ready & sel_r_s);
    nak_s      = |(send_data_err & sel_r_s);
    case (state_r)
      ST_IDLE: begin
        if (S_AXIS_send_tvalid && tready_r) begin
          if ({1'b0, S_AXIS_send_tdest} < NUM_LINK_W) begin
            beat_s     = S_AXIS_send_tdata;
            dest_s     = S_AXIS_send_tdest;
            widx_s     = '0;
            state_s    = ST_SEND;
            load_s     = 1'b1;
            load_sel_s = link_sel(S_AXIS_send_tdest);
            word_s     = beat_word(S_AXIS_send_tdata, '0);
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hs_s && !nak_s) begin
          load_s = 1'b1;
          if (widx_r == LAST_WORD) begin
            state_s    = ST_IDLE;
            load_sel_s = '0;
            word_s     = '0;
          end else begin
            widx_s     = widx_r + RW'(1);
            load_sel_s = sel_r_s;
            word_s     = beat_word(beat_r, widx_r + RW'(1));
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
        load_s  = 1'b1;
      end
    endcase
    if (load_s) begin
      tx_valid_s = load_sel_s;
      for (int k = 0; k < NUM_LINK; k++) tx_data_s[k*CW +: CW] = word_s & {CW{load_sel_s[k]}};
      tx_par_s = load_sel_s & {NUM_LINK{even_par(word_s)}};
    end else begin
      tx_valid_s = tx_valid_s;
    end
    tready_s = (state_s == ST_IDLE);
  end

  // Ingress state and registered link outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      beat_r     <= '0;
      dest_r     <= '0;
      widx_r     <= '0;
      tx_valid_r <= '0;
      tx_data_r  <= '0;
      tx_par_r   <= '0;
      tready_r   <= 1'b1;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      beat_r     <= beat_s;
      dest_r     <= dest_s;
      widx_r     <= widx_s;
      tx_valid_r <= tx_valid_s;
      tx_data_r  <= tx_data_s;
      tx_par_r   <= tx_par_s;
      tready_r   <= tready_s;
      drop_r     <= drop_s;
    end
  end

  // ---------------- Egress ----------------
  logic [DATA_WIDTH-1:0] rx_shift_r [NUM_LINK];
  logic [RW-1:0]         rx_cnt_r   [NUM_LINK];
  logic [NUM_LINK-1:0]   rx_full_r, rx_ready_r, rx_err_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic [LW-1:0]         m_id_r;
  logic [LW-1:0]         rr_ptr_r;
  logic                  m_hs_s;
  logic                  pick_valid_s;
  logic [LW-1:0]         pick_s;
  logic [DATA_WIDTH-1:0] pick_data_s;

  assign m_hs_s = m_valid_r & M_AXIS_recv_tready;

  // Round-robin pick of the first full link at or after the pointer.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_s       = '0;
    pick_data_s  = '0;
    for (int i = 0; i < NUM_LINK; i++) begin
      for (int k = 0; k < NUM_LINK; k++) begin
        if (!pick_valid_s && rx_full_r[k] && (k == (int'(rr_ptr_r) + i) % NUM_LINK)) begin
          pick_valid_s = 1'b1;
          pick_s       = LW'(k);
          pick_data_s  = rx_shift_r[k];
        end else begin
          pick_valid_s = pick_valid_s;
        end
      end
    end
  end

  // Per-link word assembly with parity check; a full link waits for its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full_r  <= '0;
      rx_ready_r <= '1;
      rx_err_r   <= '0;
      for (int k = 0; k < NUM_LINK; k++) begin
        rx_shift_r[k] <= '0;
        rx_cnt_r[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LINK; k++) begin
        rx_err_r[k] <= 1'b0;
        if (m_hs_s && (m_id_r == LW'(k))) begin
          rx_full_r[k]  <= 1'b0;
          rx_ready_r[k] <= 1'b1;
        end else if (recv_data_valid[k] && rx_ready_r[k]) begin
          if (recv_data_par[k] != even_par(recv_data_in[k*CW +: CW])) begin
            rx_err_r[k] <= 1'b1;
          end else begin
            rx_shift_r[k] <= (rx_shift_r[k] << CW) | DATA_WIDTH'(recv_data_in[k*CW +: CW]);
            if (rx_cnt_r[k] == LAST_WORD) begin
              rx_cnt_r[k]   <= '0;
              rx_full_r[k]  <= 1'b1;
              rx_ready_r[k] <= 1'b0;
            end else begin
              rx_cnt_r[k] <= rx_cnt_r[k] + RW'(1);
            end
          end
        end
      end
    end
  end

  // Registered M_AXIS output stage; pointer moves past the link just delivered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_id_r    <= '0;
      rr_ptr_r  <= '0;
    end else if (m_hs_s) begin
      m_valid_r <= 1'b0;
      rr_ptr_r  <= (m_id_r == LAST_LINK) ? '0 : m_id_r + LW'(1);
    end else if (!m_valid_r && pick_valid_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= pick_data_s;
      m_id_r    <= pick_s;
    end
  end

  // ---------------- tik generator ----------------
  logic [TIK_WIDTH-1:0] tik_phase_r;
  logic                 tik_r;
  logic [TIK_WIDTH-1:0] tik_cnt_r;

  // Periodic one-cycle tik; disabling clears the phase but keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tik_phase_r <= '0;
      tik_r       <= 1'b0;
      tik_cnt_r   <= '0;
    end else if (!tik_en || (tik_period == '0)) begin
      tik_phase_r <= '0;
      tik_r       <= 1'b0;
    end else if (tik_phase_r >= tik_period - TIK_WIDTH'(1)) begin
      tik_phase_r <= '0;
      tik_r       <= 1'b1;
      tik_cnt_r   <= tik_cnt_r + TIK_WIDTH'(1);
    end else begin
      tik_phase_r <= tik_phase_r + TIK_WIDTH'(1);
      tik_r       <= 1'b0;
    end
  end

  assign S_AXIS_send_tready = tready_r;
  assign send_data_out      = tx_data_r;
  assign send_data_valid    = tx_valid_r;
  assign send_data_par      = tx_par_r;
  assign status_drop        = drop_r;
  assign recv_data_ready    = rx_ready_r;
  assign recv_data_err      = rx_err_r;
  assign M_AXIS_recv_tdata  = m_data_r;
  assign M_AXIS_recv_tvalid = m_valid_r;
  assign M_AXIS_recv_tid    = m_id_r;
  assign M_AXIS_recv_tlast  = 1'b1;
  assign tik                = tik_r;
  assign tik_cnt            = tik_cnt_r;

endmodule

// File: tb/tb_pcss_axis_link_bridge.sv
// Directed self-checking bench for pcss_axis_link_bridge.
module tb_pcss_axis_link_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic [1:0]  s_tdest;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic [1:0]  m_tid;
  logic        m_tlast;
  logic        m_tready;
  logic        tik_en;
  logic [23:0] tik_period;
  logic        tik;
  logic [23:0] tik_cnt;
  logic [63:0] sd_out;
  logic [3:0]  sd_valid, sd_par, sd_ready, sd_err;
  logic [63:0] rd_in;
  logic [3:0]  rd_valid, rd_par, rd_ready, rd_err;
  logic        drop;

  // second instance with three links, used for the misroute case
  logic        s1_tvalid;
  logic [1:0]  s1_tdest;
  logic        s1_tready;
  logic [63:0] m1_tdata;
  logic        m1_tvalid, m1_tlast;
  logic [1:0]  m1_tid;
  logic        tik1;
  logic [23:0] tik1_cnt;
  logic [47:0] sd1_out;
  logic [2:0]  sd1_valid, sd1_par, rd1_ready, rd1_err;
  logic        drop1;

  int n_vec  = 0;
  int n_miss = 0;
  int hs0_cnt = 0;
  int err0_cnt = 0;
  int tik_pulses = 0;
  int tik_wide = 0;
  logic tik_prev = 1'b0;

  always #5 clk = ~clk;

  pcss_axis_link_bridge dut (
    .clk(clk), .rst(rst),
    .S_AXIS_send_tdata(s_tdata), .S_AXIS_send_tvalid(s_tvalid),
    .S_AXIS_send_tdest(s_tdest), .S_AXIS_send_tready(s_tready),
    .M_AXIS_recv_tdata(m_tdata), .M_AXIS_recv_tvalid(m_tvalid),
    .M_AXIS_recv_tid(m_tid), .M_AXIS_recv_tlast(m_tlast), .M_AXIS_recv_tready(m_tready),
    .tik_en(tik_en), .tik_period(tik_period), .tik(tik), .tik_cnt(tik_cnt),
    .send_data_out(sd_out), .send_data_valid(sd_valid), .send_data_par(sd_par),
    .send_data_ready(sd_ready), .send_data_err(sd_err),
    .recv_data_in(rd_in), .recv_data_valid(rd_valid), .recv_data_par(rd_par),
    .recv_data_ready(rd_ready), .recv_data_err(rd_err), .status_drop(drop)
  );

  pcss_axis_link_bridge #(.NUM_LINK(3)) dut3 (
    .clk(clk), .rst(rst),
    .S_AXIS_send_tdata(64'h0123_4567_89AB_CDEF), .S_AXIS_send_tvalid(s1_tvalid),
    .S_AXIS_send_tdest(s1_tdest), .S_AXIS_send_tready(s1_tready),
    .M_AXIS_recv_tdata(m1_tdata), .M_AXIS_recv_tvalid(m1_tvalid),
    .M_AXIS_recv_tid(m1_tid), .M_AXIS_recv_tlast(m1_tlast), .M_AXIS_recv_tready(1'b1),
    .tik_en(1'b0), .tik_period(24'd0), .tik(tik1), .tik_cnt(tik1_cnt),
    .send_data_out(sd1_out), .send_data_valid(sd1_valid), .send_data_par(sd1_par),
    .send_data_ready(3'b111), .send_data_err(3'b000),
    .recv_data_in(48'h0), .recv_data_valid(3'b000), .recv_data_par(3'b000),
    .recv_data_ready(rd1_ready), .recv_data_err(rd1_err), .status_drop(drop1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for an M_AXIS beat, snapshots it, then lets the handshake happen.
  task automatic wait_beat(output logic [63:0] d, output logic [1:0] id,
                           output logic last, output logic [3:0] rr);
    int n = 0;
    while (!m_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_tvalid) chk("beat_timeout", 64'd0, 64'd1);
    d    = m_tdata;
    id   = m_tid;
    last = m_tlast;
    rr   = rd_ready;
    @(negedge clk);
  endtask

  // link 0 send handshakes (including NAKed ones)
  always @(posedge clk) if (sd_valid[0] && sd_ready[0]) hs0_cnt <= hs0_cnt + 1;

  // egress parity errors on link 0 and tik pulse shape
  always @(negedge clk) begin
    if (rd_err[0]) err0_cnt <= err0_cnt + 1;
    if (tik) tik_pulses <= tik_pulses + 1;
    if (tik && tik_prev) tik_wide <= tik_wide + 1;
    tik_prev <= tik;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [15:0] ord_w  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] rty_w  [5] = '{16'h0001, 16'h4567, 16'h4567, 16'h89AB, 16'hCDEF};
  logic        rty_p  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        rty_e  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] par_w  [5] = '{16'h1234, 16'h5678, 16'h9ABC, 16'h9ABC, 16'hDEF0};
  logic        par_p  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [63:0] bd;
    logic [1:0]  bid;
    logic        blast;
    logic [3:0]  brr;
    int base;

    rst = 1'b1; s_tdata = 64'h0; s_tvalid = 1'b0; s_tdest = 2'd0;
    m_tready = 1'b1; tik_en = 1'b0; tik_period = 24'd0;
    sd_ready = 4'hF; sd_err = 4'h0; rd_in = 64'h0; rd_valid = 4'h0; rd_par = 4'h0;
    s1_tvalid = 1'b0; s1_tdest = 2'd0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tready", {63'd0, s_tready}, 64'd1);
    chk("rst_send_valid", {60'd0, sd_valid}, 64'd0);
    chk("rst_recv_ready", {60'd0, rd_ready}, 64'hF);
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tik_cnt", {40'd0, tik_cnt}, 64'd0);
    chk("rst_drop", {63'd0, drop}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ingress order, link 2, ready tied high
    s_tdata = 64'h1111_2222_3333_4444; s_tdest = 2'd2; s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ord_valid", {60'd0, sd_valid}, 64'h4);
      chk("ord_word", {48'd0, sd_out[32 +: 16]}, {48'd0, ord_w[i]});
      chk("ord_par", {63'd0, sd_par[2]}, 64'd0);
      chk("ord_tready", {63'd0, s_tready}, 64'd0);
      @(negedge clk);
    end
    chk("ord_tready_back", {63'd0, s_tready}, 64'd1);
    chk("ord_idle", {60'd0, sd_valid}, 64'd0);

    // ingress retry, link 0 NAKs word 1 once
    base = hs0_cnt;
    s_tdata = 64'h0001_4567_89AB_CDEF; s_tdest = 2'd0; s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rty_valid", {60'd0, sd_valid}, 64'h1);
      chk("rty_word", {48'd0, sd_out[0 +: 16]}, {48'd0, rty_w[i]});
      chk("rty_par", {63'd0, sd_par[0]}, {63'd0, rty_p[i]});
      sd_err = {3'b000, rty_e[i]};
      @(negedge clk);
    end
    sd_err = 4'h0;
    chk("rty_tready_back", {63'd0, s_tready}, 64'd1);
    chk("rty_idle", {60'd0, sd_valid}, 64'd0);
    chk("rty_handshakes", 64'(hs0_cnt - base), 64'd5);

    // egress merge, links 1 and 3 complete in the same cycle
    rd_valid = 4'b1010; rd_par = 4'b0000;
    rd_in = {16'hBBBB, 16'h0000, 16'hAAAA, 16'h0000};
    repeat (4) @(negedge clk);
    rd_valid = 4'h0;
    wait_beat(bd, bid, blast, brr);
    chk("merge1_tid", {62'd0, bid}, 64'd1);
    chk("merge1_data", bd, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("merge1_tlast", {63'd0, blast}, 64'd1);
    chk("merge1_wait_ready3", {63'd0, brr[3]}, 64'd0);
    wait_beat(bd, bid, blast, brr);
    chk("merge2_tid", {62'd0, bid}, 64'd3);
    chk("merge2_data", bd, 64'hBBBB_BBBB_BBBB_BBBB);
    chk("merge2_tlast", {63'd0, blast}, 64'd1);
    @(negedge clk);
    chk("merge_ready_back", {60'd0, rd_ready}, 64'hF);

    // egress parity: word 2 of link 0 first arrives with bad parity
    base = err0_cnt;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 4'b0001;
      rd_in = {48'h0, par_w[i]};
      rd_par = {3'b000, par_p[i]};
      @(negedge clk);
      if (i == 2) chk("par_err_pulse", {60'd0, rd_err}, 64'h1);
      if (i == 3) begin
        chk("par_not_full", {63'd0, rd_ready[0]}, 64'd1);
        chk("par_no_beat_yet", {63'd0, m_tvalid}, 64'd0);
      end
    end
    rd_valid = 4'h0; rd_par = 4'h0;
    wait_beat(bd, bid, blast, brr);
    chk("par_beat_tid", {62'd0, bid}, 64'd0);
    chk("par_beat_data", bd, 64'h1234_5678_9ABC_DEF0);
    chk("par_err_count", 64'(err0_cnt - base), 64'd1);

    // misroute on the three-link instance
    s1_tdest = 2'd3; s1_tvalid = 1'b1;
    @(negedge clk);
    s1_tvalid = 1'b0;
    chk("drop_flag", {63'd0, drop1}, 64'd1);
    chk("drop_no_valid", {61'd0, sd1_valid}, 64'd0);
    chk("drop_tready", {63'd0, s1_tready}, 64'd1);
    @(negedge clk);
    chk("drop_sticky", {63'd0, drop1}, 64'd1);
    chk("drop_main_clear", {63'd0, drop}, 64'd0);

    // reset in the middle of a stalled SEND
    sd_ready = 4'h0;
    s_tdata = 64'hDEAD_BEEF_CAFE_F00D; s_tdest = 2'd1; s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("stall_valid", {60'd0, sd_valid}, 64'h2);
    @(negedge clk);
    chk("stall_hold_word", {48'd0, sd_out[16 +: 16]}, 64'hDEAD);
    chk("stall_tready", {63'd0, s_tready}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {60'd0, sd_valid}, 64'd0);
    chk("rst_mid_tready", {63'd0, s_tready}, 64'd1);
    chk("rst_mid_drop", {63'd0, drop1}, 64'd0);
    @(negedge clk);
    rst = 1'b0; sd_ready = 4'hF;
    @(negedge clk);
    chk("post_rst_valid", {60'd0, sd_valid}, 64'd0);

    // tik, period 10 for 100 cycles
    base = tik_pulses;
    tik_period = 24'd10; tik_en = 1'b1;
    repeat (100) @(negedge clk);
    tik_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("tik_pulses", 64'(tik_pulses - base), 64'd10);
    chk("tik_cnt", {40'd0, tik_cnt}, 64'd10);
    chk("tik_one_cycle", 64'(tik_wide), 64'd0);

    // tik, period 0 gives no pulses
    tik_period = 24'd0; tik_en = 1'b1;
    repeat (30) @(negedge clk);
    tik_en = 1'b0;
    @(negedge clk);
    chk("tik_zero_pulses", 64'(tik_pulses - base), 64'd10);
    chk("tik_zero_cnt", {40'd0, tik_cnt}, 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
